// File: rtl/program_loader.sv
// program_loader: receives a byte stream (count byte, then big-endian 32-bit
// words), writes each word to instruction memory and holds the processor in
// reset until the load completes.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte before the load is declared done.
module program_loader #(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wen,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_clr,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic [31:0] addr_full;

    assign accept    = in_valid && in_ready;
    assign addr_full = 32'(word_idx_q) * 32'(ADDR_STEP);

    // Outputs decoded from the current state; in_ready is also gated by clr
    // so no byte is ever acknowledged in a reset cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!clr) begin
            in_ready = (state_q == IDLE) || (state_q == LOAD)
`ifdef LOADER_CHECKSUM_EN
                    || (state_q == CHECK)
`endif
                    ;
        end
        mem_wen  = (state_q == WRITE);
        mem_addr = addr_q;
        mem_data = data_q;
        cpu_clr  = (state_q != DONE);
        done     = (state_q == DONE);
        error    = (state_q == ERROR);
    end

    // Next-state logic. The write address/data registers are loaded on the
    // 4th byte so they are already valid during the WRITE cycle and then hold.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        count_d    = in_data;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    word_d     = {word_q[23:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        addr_d  = addr_full[7:0];
                        data_d  = {word_q[23:0], in_data};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 8'd1;
                if ((word_idx_q + 8'd1) < count_q) begin
                    state_d = LOAD;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            default: ;
        endcase
    end

    // State registers with synchronous clear; clr wins over any transfer.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a per-cycle vector table for the basic
// single-word load, then directed sequences for gaps, bad counts, full-size
// load, mid-load clear and (when LOADER_CHECKSUM_EN is defined) checksums.
module tb_program_loader;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wen;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        cpu_clr;
    logic        done;
    logic        error;

    program_loader #(.MAX_WORDS(64), .ADDR_STEP(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_clr  (cpu_clr),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        clr;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] mdata;
        logic        cpu_clr;
        logic        done;
        logic        err;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs[$];
    wr_t         wlog[$];
    logic [31:0] ld_words[$];

    // Every write pulse seen by memory is logged, sampled away from posedge.
    always @(negedge clk) begin
        if (mem_wen === 1'b1) wlog.push_back('{addr: mem_addr, data: mem_data});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic c, input logic v, input logic [7:0] d,
                           input logic r, input logic w, input logic [7:0] a,
                           input logic [31:0] md, input logic cc, input logic dn,
                           input logic er);
        vecs.push_back('{clr: c, valid: v, data: d, ready: r, wen: w, addr: a,
                         mdata: md, cpu_clr: cc, done: dn, err: er});
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        wlog.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Present a byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
    endtask

    // Load count n followed by ld_words; cs_mask flips checksum bits if used.
    task automatic load(input logic [7:0] n, input bit gaps, input logic [7:0] cs_mask);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(n, 0);
        foreach (ld_words[i]) begin
            w = ld_words[i];
            for (int unsigned k = 0; k < 4; k++) begin
                send_byte(w[31:24], gaps ? int'($urandom_range(0, 3)) : 0);
                cs = cs ^ w[31:24];
                w  = w << 8;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs ^ cs_mask, 0);
`else
        if (cs_mask != 8'h00) cs = cs ^ cs_mask;
`endif
        idle(3);
    endtask

    initial begin
        clr      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);

        // ---- single-word load, cycle by cycle ----
        add_vec(1, 0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 0);
        add_vec(0, 1, 8'h01, 1, 0, 8'h00, 32'h0,        1, 0, 0);
        add_vec(0, 1, 8'h20, 1, 0, 8'h00, 32'h0,        1, 0, 0);
        add_vec(0, 1, 8'h08, 1, 0, 8'h00, 32'h0,        1, 0, 0);
        add_vec(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0);
        add_vec(0, 1, 8'h05, 1, 0, 8'h00, 32'h0,        1, 0, 0);
        add_vec(0, 0, 8'h00, 0, 1, 8'h00, 32'h20080005, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
        add_vec(0, 1, 8'h2D, 1, 0, 8'h00, 32'h20080005, 1, 0, 0);
`endif
        add_vec(0, 0, 8'h00, 0, 0, 8'h00, 32'h20080005, 0, 1, 0);
        add_vec(0, 1, 8'hFF, 0, 0, 8'h00, 32'h20080005, 0, 1, 0);
        add_vec(0, 0, 8'h00, 0, 0, 8'h00, 32'h20080005, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr      = vecs[i].clr;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d.mem_wen",  i), 32'(mem_wen),  32'(vecs[i].wen));
            chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d.mem_data", i), mem_data,      vecs[i].mdata);
            chk($sformatf("v%0d.cpu_clr",  i), 32'(cpu_clr),  32'(vecs[i].cpu_clr));
            chk($sformatf("v%0d.done",     i), 32'(done),     32'(vecs[i].done));
            chk($sformatf("v%0d.error",    i), 32'(error),    32'(vecs[i].err));
        end
        chk("single.write_count", 32'(wlog.size()), 32'd1);

        // ---- two words with random valid gaps ----
        do_reset();
        ld_words = '{32'h8C010000, 32'hAC020004};
        load(8'h02, 1'b1, 8'h00);
        chk("gaps.write_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("gaps.addr0", 32'(wlog[0].addr), 32'h00);
            chk("gaps.data0", wlog[0].data, 32'h8C010000);
            chk("gaps.addr1", 32'(wlog[1].addr), 32'h04);
            chk("gaps.data1", wlog[1].data, 32'hAC020004);
        end
        chk("gaps.done", 32'(done), 32'd1);
        chk("gaps.cpu_clr", 32'(cpu_clr), 32'd0);

        // ---- bad counts: 0 and 65 ----
        for (int unsigned j = 0; j < 2; j++) begin
            do_reset();
            send_byte((j == 0) ? 8'h00 : 8'h41, 0);
            idle(3);
            #1;
            chk($sformatf("badn%0d.error", j),    32'(error),    32'd1);
            chk($sformatf("badn%0d.cpu_clr", j),  32'(cpu_clr),  32'd1);
            chk($sformatf("badn%0d.in_ready", j), 32'(in_ready), 32'd0);
            chk($sformatf("badn%0d.done", j),     32'(done),     32'd0);
            chk($sformatf("badn%0d.writes", j),   32'(wlog.size()), 32'd0);
        end

        // ---- full 64-word load, then extra bytes ignored ----
        do_reset();
        ld_words.delete();
        for (int i = 0; i < 64; i++)
            ld_words.push_back({8'(i), 8'hA5, ~8'(i), 8'(i * 3)});
        load(8'h40, 1'b0, 8'h00);
        chk("full.write_count", 32'(wlog.size()), 32'd64);
        for (int i = 0; i < wlog.size() && i < 64; i++) begin
            if (wlog[i].addr !== 8'(i * 4) || wlog[i].data !== ld_words[i])
                chk($sformatf("full.word%0d", i), wlog[i].data, ld_words[i]);
        end
        if (wlog.size() == 64) chk("full.last_addr", 32'(wlog[63].addr), 32'hFC);
        chk("full.done", 32'(done), 32'd1);
        repeat (8) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        idle(2);
        #1;
        chk("full.extra_writes", 32'(wlog.size()), 32'd64);
        chk("full.done_hold", 32'(done), 32'd1);
        chk("full.addr_hold", 32'(mem_addr), 32'hFC);

        // ---- clear mid-load with a simultaneous byte, then reload ----
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        #1;
        chk("abort.ready_in_clr", 32'(in_ready), 32'd0);
        chk("abort.wen_in_clr", 32'(mem_wen), 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.mem_addr", 32'(mem_addr), 32'h00);
        chk("abort.mem_data", mem_data, 32'h0);
        chk("abort.cpu_clr", 32'(cpu_clr), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.error", 32'(error), 32'd0);
        chk("abort.writes", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) chk("abort.word0", wlog[0].data, 32'h11223344);
        ld_words = '{32'hDEADBEEF};
        load(8'h01, 1'b0, 8'h00);
        chk("reload.writes", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("reload.addr", 32'(wlog[1].addr), 32'h00);
            chk("reload.data", wlog[1].data, 32'hDEADBEEF);
        end
        chk("reload.done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // ---- checksum good (0x08) and bad (0x09) ----
        do_reset();
        ld_words = '{32'h12345678};
        load(8'h01, 1'b0, 8'h00);
        chk("cs_good.done", 32'(done), 32'd1);
        chk("cs_good.error", 32'(error), 32'd0);
        do_reset();
        load(8'h01, 1'b0, 8'h01);
        chk("cs_bad.error", 32'(error), 32'd1);
        chk("cs_bad.done", 32'(done), 32'd0);
        chk("cs_bad.cpu_clr", 32'(cpu_clr), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
